// File: rtl/count_sched.sv
// Round-robin scheduler sharing a +STEP_HI/+STEP_LO accumulator between two burst requesters.
// Optional build macro COUNT_SCHED_SAT_EN makes the accumulator saturate instead of wrapping.
module count_sched #(
  parameter int WIDTH   = 8,
  parameter int LEN_W   = 4,
  parameter int STEP_HI = 2,
  parameter int STEP_LO = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [1:0]         req,
  input  logic [1:0]         req_sel,
  input  logic [2*LEN_W-1:0] req_len,
  output logic [1:0]         grant,
  output logic [1:0]         done,
  output logic               busy,
  output logic [WIDTH-1:0]   out_num
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_ptr, w_ptr_nxt;
  logic               r_win, w_win_nxt;
  logic               r_sel, w_sel_nxt;
  logic [LEN_W-1:0]   r_rem, w_rem_nxt;
  logic [1:0]         r_grant, w_grant_nxt;
  logic [1:0]         r_done, w_done_nxt;
  logic               r_busy, w_busy_nxt;
  logic [WIDTH-1:0]   r_out, w_out_nxt;
  logic               w_cand;
  logic [LEN_W-1:0]   w_len;

  function automatic logic [WIDTH-1:0] acc_step(input logic [WIDTH-1:0] a, input logic sel);
`ifdef COUNT_SCHED_SAT_EN
    logic [WIDTH:0] s;
    s = {1'b0, a} + (WIDTH+1)'(sel ? STEP_HI : STEP_LO);
    return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
`else
    return a + WIDTH'(sel ? STEP_HI : STEP_LO);
`endif
  endfunction

  // Both requesting: pointer wins; otherwise the single requester (req[1] picks index 1).
  assign w_cand = (req == 2'b11) ? r_ptr : req[1];
  assign w_len  = w_cand ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_win_nxt   = r_win;
    w_sel_nxt   = r_sel;
    w_rem_nxt   = r_rem;
    w_grant_nxt = r_grant;
    w_done_nxt  = 2'b00;
    w_out_nxt   = r_out;
    case (r_state)
      S_IDLE: begin
        if (req != 2'b00) begin
          w_win_nxt   = w_cand;
          w_sel_nxt   = req_sel[w_cand];
          w_grant_nxt = w_cand ? 2'b10 : 2'b01;
          if (w_len == '0) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = w_cand ? 2'b10 : 2'b01;
          end else begin
            w_rem_nxt   = w_len;
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        w_out_nxt = acc_step(r_out, r_sel);
        w_rem_nxt = r_rem - 1'b1;
        if (r_rem == LEN_W'(1)) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = r_grant;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = 2'b00;
        w_ptr_nxt   = ~r_win;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_ptr   <= 1'b0;
      r_win   <= 1'b0;
      r_sel   <= 1'b0;
      r_rem   <= '0;
      r_grant <= 2'b00;
      r_done  <= 2'b00;
      r_busy  <= 1'b0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_win   <= w_win_nxt;
      r_sel   <= w_sel_nxt;
      r_rem   <= w_rem_nxt;
      r_grant <= w_grant_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
      r_out   <= w_out_nxt;
    end
  end

  assign grant   = r_grant;
  assign done    = r_done;
  assign busy    = r_busy;
  assign out_num = r_out;

endmodule

// File: tb/tb_count_sched.sv
// Scoreboard bench for count_sched: driver queues expected per-cycle outputs, monitor checks busy cycles.
module tb_count_sched;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] req_sel = 2'b00;
  logic [7:0] req_len = 8'h00;
  logic [1:0] grant;
  logic [1:0] done;
  logic       busy;
  logic [7:0] out_num;

  typedef struct {
    logic [1:0] g;
    logic [1:0] d;
    logic [7:0] o;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_out = 0;

  count_sched dut (
    .CLK(CLK), .RST(RST), .req(req), .req_sel(req_sel), .req_len(req_len),
    .grant(grant), .done(done), .busy(busy), .out_num(out_num)
  );

  always #5 CLK = ~CLK;

  function automatic int step_model(input int v, input logic s);
    int r;
    r = v + (s ? 2 : 3);
`ifdef COUNT_SCHED_SAT_EN
    return (r > 255) ? 255 : r;
`else
    return r % 256;
`endif
  endfunction

  // Monitor: every busy cycle must match the oldest queued expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (busy) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_busy: grant=%b done=%b out=%0d, required no active burst", grant, done, out_num);
      end else begin
        e = q.pop_front();
        if (grant !== e.g || done !== e.d || out_num !== e.o) begin
          n_err++;
          $display("FAIL burst_cycle: grant=%b done=%b out=%0d, required grant=%b done=%b out=%0d",
                   grant, done, out_num, e.g, e.d, e.o);
        end
      end
    end
  end

  task automatic push_burst(input int w, input logic s, input int len);
    exp_t e;
    for (int k = 0; k <= len; k++) begin
      e.g = (w == 1) ? 2'b10 : 2'b01;
      e.d = (k == len) ? e.g : 2'b00;
      e.o = 8'(exp_out);
      q.push_back(e);
      if (k < len) exp_out = step_model(exp_out, s);
    end
  endtask

  task automatic check_idle(input string name);
    n_vec++;
    if (grant !== 2'b00 || done !== 2'b00 || busy !== 1'b0 || out_num !== 8'd0) begin
      n_err++;
      $display("FAIL %s: grant=%b done=%b busy=%b out=%0d, required all zero", name, grant, done, busy, out_num);
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge CLK);
    RST = 1'b1;
    req = 2'b00;
    @(negedge CLK);
    RST = 1'b0;
    exp_out = 0;
    check_idle(name);
  endtask

  task automatic run_burst(input int w, input logic s, input int len);
    logic [3:0] l4;
    l4 = 4'(len);
    req_sel[w] = s;
    req_len[w*4 +: 4] = l4;
    push_burst(w, s, len);
    req[w] = 1'b1;
    repeat (len + 1) @(negedge CLK);
    req[w] = 1'b0;
    @(negedge CLK);
  endtask

  task automatic run_pair(input int f, input logic [1:0] sel, input int l0, input int l1);
    int lf, ls;
    lf = (f == 0) ? l0 : l1;
    ls = (f == 0) ? l1 : l0;
    req_sel = sel;
    req_len = {4'(l1), 4'(l0)};
    push_burst(f, sel[f], lf);
    push_burst(1 - f, sel[1 - f], ls);
    req = 2'b11;
    repeat (lf + 1) @(negedge CLK);
    req[f] = 1'b0;
    repeat (ls + 2) @(negedge CLK);
    req[1 - f] = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    // Basic burst: requester 0, step 2, len 3 -> 2,4,6.
    do_reset("reset_initial");
    run_burst(0, 1'b1, 3);
    check_idle_nonzero(8'd6);

    // Both requesting, pointer 0: r0 step 3 len 2, then r1 step 2 len 2.
    do_reset("reset_pair");
    run_pair(0, 2'b10, 2, 2);

    // Zero-length burst.
    do_reset("reset_len0");
    run_burst(0, 1'b1, 0);

    // Six len-15 step-3 bursts: wrap ends at 14, saturate at 255.
    do_reset("reset_long");
    for (int b = 0; b < 6; b++) run_burst(b % 2, 1'b0, 15);
    n_vec++;
`ifdef COUNT_SCHED_SAT_EN
    if (out_num !== 8'd255) begin
      n_err++;
      $display("FAIL final_sat: out=%0d, required 255", out_num);
    end
`else
    if (out_num !== 8'd14) begin
      n_err++;
      $display("FAIL final_wrap: out=%0d, required 14", out_num);
    end
`endif

    // Mid-burst reset: r0 burst moves pointer to 1, r1 burst is reset, then r0 must win.
    do_reset("reset_mid_pre");
    run_burst(0, 1'b1, 1);
    req_sel[1] = 1'b1;
    req_len[7:4] = 4'd5;
    push_burst(1, 1'b1, 1);
    q.pop_back();
    begin
      exp_t e;
      e.g = 2'b10; e.d = 2'b00; e.o = 8'd4;
      q.push_back(e);
    end
    req[1] = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    req = 2'b00;
    @(negedge CLK);
    RST = 1'b0;
    exp_out = 0;
    check_idle("after_mid_reset");
    run_pair(0, 2'b11, 1, 1);

    // Inputs changed during the burst are ignored.
    do_reset("reset_ignore");
    req_sel[0] = 1'b1;
    req_len[3:0] = 4'd4;
    push_burst(0, 1'b1, 4);
    req[0] = 1'b1;
    repeat (2) @(negedge CLK);
    req[0] = 1'b0;
    req_sel[0] = 1'b0;
    req_len[3:0] = 4'd9;
    repeat (3) @(negedge CLK);
    @(negedge CLK);
    check_idle_nonzero(8'd8);

    repeat (3) @(negedge CLK);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drained: %0d entries left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  task automatic check_idle_nonzero(input logic [7:0] o);
    n_vec++;
    if (grant !== 2'b00 || done !== 2'b00 || busy !== 1'b0 || out_num !== o) begin
      n_err++;
      $display("FAIL idle_after_burst: grant=%b done=%b busy=%b out=%0d, required 00 00 0 %0d",
               grant, done, busy, out_num, o);
    end
  endtask

endmodule

// File: doc/count_sched.md
# count_sched

Scheduler that shares the step-programmable accumulating counter (+2 / +3 per clock) between two requesters. Each requester asks for a burst of N increments with its own step select. A round-robin arbiter grants the counter to one requester at a time, runs the burst and pulses a per-requester `done`. The block owns the 8-bit accumulator `out_num` and sits between the control logic and any consumer of the count.

## Interface
- `WIDTH`, 8: accumulator width.
- `LEN_W`, 4: burst-length field width.
- `STEP_HI`, 2: increment when step select = 1.
- `STEP_LO`, 3: increment when step select = 0.

Ports:
- `CLK` in 1: single clock, all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `req` in 2: per-requester request level; bit i belongs to requester i.
- `req_sel` in 2: per-requester step select (1 → STEP_HI, 0 → STEP_LO).
- `req_len` in 2*LEN_W: per-requester burst length; requester i uses bits [i*LEN_W +: LEN_W].
- `grant` out 2: one-hot grant, registered.
- `done` out 2: one-cycle completion pulse for the granted requester.
- `busy` out 1: high in RUN or DONE.
- `out_num` out WIDTH: accumulator value.

## Operation
- Reset values: `out_num`=0, `grant`=0, `done`=0, `busy`=0, state=IDLE, priority pointer=0, remaining=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If no `req` bit is set, stay in IDLE.
  - Otherwise pick the winner: if both bits are set, the pointer index wins; if one bit is set, that requester wins.
  - Set `grant` to the winner and latch the winner's `req_sel` and `req_len`.
  - If the latched len = 0, go to DONE; otherwise load remaining = len and go to RUN.
- RUN:
  - Each cycle: `out_num` += step, remaining -= 1.
  - When remaining goes 1→0 on this edge, go to DONE.
- DONE:
  - `done[winner]`=1 for exactly this cycle; `grant` is still held.
  - Next edge: go to IDLE, `grant`=0, pointer = the other requester.
- Inputs are latched at grant. Changes to `req_sel`/`req_len` or a drop of `req` during RUN are ignored; the burst always completes.
- Requester contract: deassert `req` in the cycle `done` is seen. If `req` is still high when IDLE next samples it, that is a new request.
- Arithmetic: `out_num` is unsigned WIDTH bits. The sum is taken modulo 2^WIDTH (wraps), unless SAT is compiled in (see Configuration).
- Reset mid-burst: all state returns to reset values on that edge. No `done` is issued and the burst is lost.

## Timing
- `req` high in IDLE at edge E0:
  - `grant` is visible after E0.
  - First increment at E1; increment k lands at E(k).
  - DONE is entered at E(len) and `done` is high between E(len) and E(len+1).
  - `grant` drops at E(len+1).
- len = 0: `done` is high in the cycle after E0, with no change to `out_num`.
- Back-to-back service: with the other requester waiting, its grant appears at E(len+2). There is one IDLE cycle between bursts.
- `busy` = (state ≠ IDLE), registered with the state.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro `COUNT_SCHED_SAT_EN`:
  - Defined: the accumulator saturates at 2^WIDTH−1. Once `out_num`=255 it stays 255 until reset.
  - Undefined: modulo wrap (for example 254 + 3 = 1).
  - FSM, grant and timing are identical in both builds.

## Test plan
- Reset, then `req`=01, `req_sel[0]`=1, len0=3 → `out_num` reads 2, 4, 6 on successive edges; `done`=01 for one cycle; `grant` drops the next edge.
- After reset, `req`=11 held, both len=2, `req_sel`=10 → requester 0 served first (`out_num` 3, 6), then requester 1 (8, 10); `done` pulses 01 then 10.
- len0=0, `req`=01 → `done[0]` pulses 2 cycles after `req`; `out_num` unchanged at 0; `busy` high for 1 cycle.
- Six consecutive bursts of len=15 at step 3 (total 270) → wrap build ends at `out_num`=14; `COUNT_SCHED_SAT_EN` build ends at 255.
- Assert `RST` on the 2nd RUN cycle of a len=5 burst → next cycle `out_num`=0, `grant`=0, `done`=0; a following request starts cleanly at requester 0.
- Toggle `req_sel[0]` and drop `req[0]` during a len=4, step-2 burst → `out_num`=8 at completion and `done[0]` still pulses.
